controle_calculadora: RTL and testbench
=======================================

// Module: controle_calculadora
// PURPOSE
//  Sequencing FSM for the calculator datapath. Turns keypad events (ready/valor) into
//  synchronous single-cycle load enables for operand A, operand B, operator and clear.
//  Starts and waits on the ALU with an inicio/pronto handshake.
//  Sits between the keypad decoder and the operand registers/ALU. Replaces gated-clock
//  key selection with clock-enable pulses.
// PARAMETERS
//  DIGITOS  4  max decimal digits accepted per operand; extra digits ignored
// PORTS
//  clock             in   1  system clock; all logic on posedge
//  reset_n           in   1  asynchronous, active-low reset
//  ready             in   1  key held (level, synchronous to clock)
//  valor             in   4  key code: 0-9 digit, A=+, B=-, C=*, D='=', E=clear, F=backspace
//  pronto            in   1  ALU result valid (pulse or level)
//  estado            out  2  00 OPERANDO_A, 01 OPERANDO_B, 10 EXECUTA, 11 RESULTADO
//  digito            out  4  registered digit, valid with carrega_a/carrega_b
//  carrega_a         out  1  pulse: shift digito into operand A
//  carrega_b         out  1  pulse: shift digito into operand B
//  carrega_op        out  1  pulse: latch operacao
//  operacao          out  2  00 add (A), 01 sub (B), 10 mul (C); held
//  copia_resultado   out  1  pulse: copy ALU result into operand A (chaining)
//  inicio            out  1  pulse: start ALU
//  limpa             out  1  pulse: clear operands, operator, display
//  mostra_resultado  out  1  level: display selects ALU result
//  apaga_a, apaga_b  out  1  pulse: drop last digit of A/B (tied 0 without macro)
// BEHAVIOUR
//  - Reset (async): estado=00, every pulse output=0, operacao=00, digito=0, counters=0,
//    mostra_resultado=0. ready_q resets to 1, so a key held across reset release is not an event.
//  - Event: tecla = ready & ~ready_q. One event per press. Outputs are registered and
//    update at the edge that samples the event (1-cycle latency). Pulses last exactly 1 cycle.
//  - OPERANDO_A: digit & cont_a<DIGITOS -> carrega_a, cont_a++. Digit when full -> ignored.
//    A/B/C & cont_a>0 -> carrega_op, operacao set, go to OPERANDO_B. A/B/C with cont_a==0,
//    and D -> ignored. E -> limpa, cont_a=0.
//  - OPERANDO_B: digit -> same rule on cont_b/carrega_b. A/B/C with cont_b==0 -> replaces
//    operator (carrega_op). A/B/C with cont_b>0 -> ignored. D & cont_b>0 -> inicio, go to
//    EXECUTA. D with cont_b==0 -> ignored. E -> limpa, counters=0, go to OPERANDO_A.
//  - EXECUTA: pronto -> mostra_resultado=1, go to RESULTADO. Keys other than E are ignored.
//    E -> limpa, go to OPERANDO_A (abort). If E and pronto occur in the same cycle, E wins.
//    A pronto seen outside EXECUTA is ignored.
//  - RESULTADO: A/B/C -> copia_resultado, carrega_op (same cycle), cont_a=DIGITOS (treated
//    as full), cont_b=0, mostra_resultado=0, go to OPERANDO_B. Digit or E -> limpa,
//    counters=0, mostra_resultado=0, go to OPERANDO_A; the digit is discarded. D -> ignored.
//  - Counters are $clog2(DIGITOS+1) bits wide and saturate at DIGITOS (never wrap).
//  - Never more than one of carrega_a/carrega_b/limpa/inicio high in a cycle.
// CONFIGURATION
//  TECLA_APAGA_EN defined: F in OPERANDO_A with cont_a>0 -> apaga_a, cont_a--. F in
//    OPERANDO_B with cont_b>0 -> apaga_b, cont_b--. F in OPERANDO_B with cont_b==0 ->
//    return to OPERANDO_A (operator kept, no pulse). F is ignored in every other case.
//  TECLA_APAGA_EN undefined: F is always ignored. apaga_a and apaga_b are constant 0.
// TESTING
//  1 Keys 1,2,A,3,D, then pronto after 5 cycles -> carrega_a x2 (digito 1,2), carrega_op
//    with operacao=00, carrega_b (3), inicio, estado 10 -> 11, mostra_resultado=1.
//  2 DIGITOS=4, keys 1..6 in OPERANDO_A -> exactly 4 carrega_a, cont_a=4, estado stays 00.
//  3 Hold ready for 20 cycles -> one event. Hold ready across reset release -> no event.
//  4 Keys A and D first -> no pulses. Keys 5,A,B -> two carrega_op pulses, final operacao=01.
//  5 In EXECUTA, E and pronto in the same cycle -> limpa, estado 00, mostra_resultado=0.
//    RESULTADO then C -> copia_resultado + carrega_op, operacao=10, estado 01.
//  6 With TECLA_APAGA_EN: keys 7,8,F -> apaga_a, cont_a=1. Keys A,F -> estado 00.
//    Without TECLA_APAGA_EN: apaga_a stays 0.

Source files
------------

// File: rtl/controle_calculadora.sv
// Sequencing FSM for the calculator: keypad events become single-cycle load enables and an ALU start/done handshake.
// Optional backspace key support is enabled by defining TECLA_APAGA_EN.
module controle_calculadora #(
    parameter int DIGITOS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ready,
    input  logic [3:0] valor,
    input  logic       pronto,
    output logic [1:0] estado,
    output logic [3:0] digito,
    output logic       carrega_a,
    output logic       carrega_b,
    output logic       carrega_op,
    output logic [1:0] operacao,
    output logic       copia_resultado,
    output logic       inicio,
    output logic       limpa,
    output logic       mostra_resultado,
    output logic       apaga_a,
    output logic       apaga_b
);

    localparam int CW = $clog2(DIGITOS + 1);
    localparam logic [CW-1:0] MAXC = CW'(DIGITOS);

    typedef enum logic [1:0] {
        OPERANDO_A = 2'b00,
        OPERANDO_B = 2'b01,
        EXECUTA    = 2'b10,
        RESULTADO  = 2'b11
    } estado_t;

    estado_t       estado_q, estado_d;
    logic          ready_q;
    logic [CW-1:0] cont_a, cont_a_d;
    logic [CW-1:0] cont_b, cont_b_d;
    logic [3:0]    digito_d;
    logic [1:0]    operacao_d;
    logic          mostra_d;
    logic          carrega_a_d, carrega_b_d, carrega_op_d;
    logic          copia_d, inicio_d, limpa_d;
`ifdef TECLA_APAGA_EN
    logic          apaga_a_d, apaga_b_d;
`endif

    logic       tecla;
    logic       e_digito;
    logic       e_oper;
    logic [1:0] op_cod;

    assign tecla    = ready & ~ready_q;
    assign e_digito = (valor <= 4'd9);
    assign e_oper   = (valor == 4'hA) || (valor == 4'hB) || (valor == 4'hC);
    // A/B/C map to 00/01/10
    assign op_cod   = 2'(valor - 4'hA);
    assign estado   = estado_q;

    always_comb begin
        estado_d     = estado_q;
        cont_a_d     = cont_a;
        cont_b_d     = cont_b;
        digito_d     = digito;
        operacao_d   = operacao;
        mostra_d     = mostra_resultado;
        carrega_a_d  = 1'b0;
        carrega_b_d  = 1'b0;
        carrega_op_d = 1'b0;
        copia_d      = 1'b0;
        inicio_d     = 1'b0;
        limpa_d      = 1'b0;
`ifdef TECLA_APAGA_EN
        apaga_a_d    = 1'b0;
        apaga_b_d    = 1'b0;
`endif
        case (estado_q)
            OPERANDO_A: begin
                if (tecla) begin
                    if (e_digito) begin
                        if (cont_a < MAXC) begin
                            carrega_a_d = 1'b1;
                            digito_d    = valor;
                            cont_a_d    = cont_a + 1'b1;
                        end
                    end else if (e_oper) begin
                        if (cont_a != '0) begin
                            carrega_op_d = 1'b1;
                            operacao_d   = op_cod;
                            estado_d     = OPERANDO_B;
                        end
                    end else if (valor == 4'hE) begin
                        limpa_d  = 1'b1;
                        cont_a_d = '0;
                        cont_b_d = '0;
                    end
`ifdef TECLA_APAGA_EN
                    else if (valor == 4'hF && cont_a != '0) begin
                        apaga_a_d = 1'b1;
                        cont_a_d  = cont_a - 1'b1;
                    end
`endif
                end
            end
            OPERANDO_B: begin
                if (tecla) begin
                    if (e_digito) begin
                        if (cont_b < MAXC) begin
                            carrega_b_d = 1'b1;
                            digito_d    = valor;
                            cont_b_d    = cont_b + 1'b1;
                        end
                    end else if (e_oper) begin
                        if (cont_b == '0) begin
                            carrega_op_d = 1'b1;
                            operacao_d   = op_cod;
                        end
                    end else if (valor == 4'hD) begin
                        if (cont_b != '0) begin
                            inicio_d = 1'b1;
                            estado_d = EXECUTA;
                        end
                    end else if (valor == 4'hE) begin
                        limpa_d  = 1'b1;
                        cont_a_d = '0;
                        cont_b_d = '0;
                        estado_d = OPERANDO_A;
                    end
`ifdef TECLA_APAGA_EN
                    else if (valor == 4'hF) begin
                        if (cont_b != '0) begin
                            apaga_b_d = 1'b1;
                            cont_b_d  = cont_b - 1'b1;
                        end else begin
                            estado_d = OPERANDO_A;
                        end
                    end
`endif
                end
            end
            EXECUTA: begin
                // abort takes priority over a result arriving in the same cycle
                if (tecla && valor == 4'hE) begin
                    limpa_d  = 1'b1;
                    cont_a_d = '0;
                    cont_b_d = '0;
                    estado_d = OPERANDO_A;
                end else if (pronto) begin
                    mostra_d = 1'b1;
                    estado_d = RESULTADO;
                end
            end
            RESULTADO: begin
                if (tecla) begin
                    if (e_oper) begin
                        copia_d      = 1'b1;
                        carrega_op_d = 1'b1;
                        operacao_d   = op_cod;
                        cont_a_d     = MAXC;
                        cont_b_d     = '0;
                        mostra_d     = 1'b0;
                        estado_d     = OPERANDO_B;
                    end else if (e_digito || valor == 4'hE) begin
                        limpa_d  = 1'b1;
                        cont_a_d = '0;
                        cont_b_d = '0;
                        mostra_d = 1'b0;
                        estado_d = OPERANDO_A;
                    end
                end
            end
            default: estado_d = OPERANDO_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q         <= OPERANDO_A;
            ready_q          <= 1'b1;
            cont_a           <= '0;
            cont_b           <= '0;
            digito           <= '0;
            operacao         <= '0;
            mostra_resultado <= 1'b0;
            carrega_a        <= 1'b0;
            carrega_b        <= 1'b0;
            carrega_op       <= 1'b0;
            copia_resultado  <= 1'b0;
            inicio           <= 1'b0;
            limpa            <= 1'b0;
        end else begin
            estado_q         <= estado_d;
            ready_q          <= ready;
            cont_a           <= cont_a_d;
            cont_b           <= cont_b_d;
            digito           <= digito_d;
            operacao         <= operacao_d;
            mostra_resultado <= mostra_d;
            carrega_a        <= carrega_a_d;
            carrega_b        <= carrega_b_d;
            carrega_op       <= carrega_op_d;
            copia_resultado  <= copia_d;
            inicio           <= inicio_d;
            limpa            <= limpa_d;
        end
    end

`ifdef TECLA_APAGA_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            apaga_a <= 1'b0;
            apaga_b <= 1'b0;
        end else begin
            apaga_a <= apaga_a_d;
            apaga_b <= apaga_b_d;
        end
    end
`else
    assign apaga_a = 1'b0;
    assign apaga_b = 1'b0;
`endif

endmodule

// File: tb/tb_controle_calculadora.sv
// Directed self-checking bench for controle_calculadora (DIGITOS=4); honours TECLA_APAGA_EN when defined.
`timescale 1ns/1ps
module tb_controle_calculadora;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] valor = 4'h0;
    logic       pronto = 1'b0;
    logic [1:0] estado;
    logic [3:0] digito;
    logic       carrega_a, carrega_b, carrega_op, copia_resultado;
    logic       inicio, limpa, mostra_resultado, apaga_a, apaga_b;
    logic [1:0] operacao;

    int checks = 0;
    int errors = 0;

    int n_ca = 0, n_cb = 0, n_op = 0, n_cp = 0, n_in = 0, n_li = 0, n_aa = 0, n_ab = 0;
    int n_excl = 0;

    logic       s_ca, s_cb, s_op, s_cp, s_in, s_li, s_aa, s_ab, s_mo;
    logic [3:0] s_dig;
    logic [1:0] s_est, s_opr;

    controle_calculadora #(.DIGITOS(4)) dut (
        .clock(clock), .reset_n(reset_n), .ready(ready), .valor(valor), .pronto(pronto),
        .estado(estado), .digito(digito), .carrega_a(carrega_a), .carrega_b(carrega_b),
        .carrega_op(carrega_op), .operacao(operacao), .copia_resultado(copia_resultado),
        .inicio(inicio), .limpa(limpa), .mostra_resultado(mostra_resultado),
        .apaga_a(apaga_a), .apaga_b(apaga_b)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (carrega_a) n_ca++;
        if (carrega_b) n_cb++;
        if (carrega_op) n_op++;
        if (copia_resultado) n_cp++;
        if (inicio) n_in++;
        if (limpa) n_li++;
        if (apaga_a) n_aa++;
        if (apaga_b) n_ab++;
        if (int'(carrega_a) + int'(carrega_b) + int'(limpa) + int'(inicio) > 1) n_excl++;
    end

    task automatic verifica(input string tag, input int obs, input int esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic snap();
        s_ca = carrega_a; s_cb = carrega_b; s_op = carrega_op; s_cp = copia_resultado;
        s_in = inicio; s_li = limpa; s_aa = apaga_a; s_ab = apaga_b; s_mo = mostra_resultado;
        s_dig = digito; s_est = estado; s_opr = operacao;
    endtask

    // press key k: event sampled at the next posedge, outputs snapshotted one half-cycle later
    task automatic tecla(input logic [3:0] k);
        @(negedge clock);
        ready = 1'b1;
        valor = k;
        @(negedge clock);
        snap();
        ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic reinicia();
        @(negedge clock);
        reset_n = 1'b0;
        ready = 1'b0;
        pronto = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic pulso_pronto();
        @(negedge clock);
        pronto = 1'b1;
        @(negedge clock);
        snap();
        pronto = 1'b0;
        @(negedge clock);
    endtask

    int base;

    initial begin
        // reset state
        #2;
        verifica("rst_estado", estado, 0);
        verifica("rst_pulsos", {carrega_a, carrega_b, carrega_op, copia_resultado, inicio, limpa, apaga_a, apaga_b}, 0);
        verifica("rst_operacao", operacao, 0);
        verifica("rst_digito", digito, 0);
        verifica("rst_mostra", mostra_resultado, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: 1,2,A,3,D then pronto
        tecla(4'h1);
        verifica("t1_ca1", s_ca, 1); verifica("t1_dig1", s_dig, 1);
        tecla(4'h2);
        verifica("t1_ca2", s_ca, 1); verifica("t1_dig2", s_dig, 2);
        tecla(4'hA);
        verifica("t1_op", s_op, 1); verifica("t1_opr", s_opr, 0); verifica("t1_est_b", s_est, 1);
        tecla(4'h3);
        verifica("t1_cb", s_cb, 1); verifica("t1_dig3", s_dig, 3);
        tecla(4'hD);
        verifica("t1_inicio", s_in, 1); verifica("t1_est_exec", s_est, 2);
        repeat (5) @(negedge clock);
        verifica("t1_espera", estado, 2);
        pulso_pronto();
        verifica("t1_est_res", s_est, 3); verifica("t1_mostra", s_mo, 1);
        verifica("t1_n_ca", n_ca, 2);

        // 2: saturation at DIGITOS
        reinicia();
        base = n_ca;
        for (int unsigned i = 1; i <= 6; i++) tecla(4'(i));
        verifica("t2_n_ca", n_ca - base, 4);
        verifica("t2_estado", estado, 0);
        tecla(4'hB);
        verifica("t2_op_cheio", s_op, 1);

        // 3: held key gives one event; key held across reset release gives none
        reinicia();
        base = n_ca;
        @(negedge clock);
        ready = 1'b1; valor = 4'h7;
        repeat (20) @(negedge clock);
        ready = 1'b0;
        @(negedge clock);
        verifica("t3_um_evento", n_ca - base, 1);
        ready = 1'b1; valor = 4'h5; reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        base = n_ca;
        repeat (5) @(negedge clock);
        ready = 1'b0;
        @(negedge clock);
        verifica("t3_reset_seg", n_ca - base, 0);
        tecla(4'h5);
        verifica("t3_pos_reset", s_ca, 1);

        // 4: A/D with empty A ignored; operator replacement
        reinicia();
        base = n_op + n_in + n_li + n_ca;
        tecla(4'hA);
        tecla(4'hD);
        verifica("t4_sem_pulsos", n_op + n_in + n_li + n_ca - base, 0);
        verifica("t4_estado_a", estado, 0);
        base = n_op;
        tecla(4'h5);
        tecla(4'hA);
        tecla(4'hB);
        verifica("t4_n_op", n_op - base, 2);
        verifica("t4_operacao", operacao, 1);
        verifica("t4_estado_b", estado, 1);
        tecla(4'h9);
        base = n_op;
        tecla(4'hC);
        verifica("t4_op_ignorado", n_op - base, 0);
        tecla(4'hD);
        verifica("t4_inicio", s_in, 1);

        // pronto outside EXECUTA ignored
        reinicia();
        pulso_pronto();
        verifica("t5_pronto_fora", s_est, 0);
        verifica("t5_pronto_mostra", s_mo, 0);

        // 5: E and pronto together in EXECUTA
        tecla(4'h1); tecla(4'hA); tecla(4'h2); tecla(4'hD);
        verifica("t5_exec", estado, 2);
        @(negedge clock);
        ready = 1'b1; valor = 4'hE; pronto = 1'b1;
        @(negedge clock);
        snap();
        ready = 1'b0; pronto = 1'b0;
        @(negedge clock);
        verifica("t5_limpa", s_li, 1);
        verifica("t5_est_abort", s_est, 0);
        verifica("t5_mostra_abort", s_mo, 0);
        tecla(4'h1); tecla(4'hA); tecla(4'h2); tecla(4'hD);
        pulso_pronto();
        verifica("t5_resultado", s_est, 3);
        tecla(4'hC);
        verifica("t5_copia", s_cp, 1); verifica("t5_carrega_op", s_op, 1);
        verifica("t5_operacao", s_opr, 2); verifica("t5_est_b", s_est, 1);
        verifica("t5_mostra_off", s_mo, 0);
        tecla(4'h4);
        verifica("t5_cb_encadeado", s_cb, 1);
        tecla(4'hD);
        pulso_pronto();
        base = n_ca;
        tecla(4'h8);
        verifica("t5_digito_limpa", s_li, 1);
        verifica("t5_digito_est", s_est, 0);
        verifica("t5_digito_descartado", n_ca - base, 0);

        // 6: backspace
        reinicia();
        tecla(4'h7); tecla(4'h8);
        tecla(4'hF);
`ifdef TECLA_APAGA_EN
        verifica("t6_apaga_a", s_aa, 1);
        tecla(4'hA);
        verifica("t6_est_b", s_est, 1);
        tecla(4'hF);
        verifica("t6_volta_a", s_est, 0);
        verifica("t6_sem_apaga_b", s_ab, 0);
        tecla(4'hF);
        verifica("t6_apaga_ultimo", s_aa, 1);
        tecla(4'hF);
        verifica("t6_vazio", s_aa, 0);
`else
        verifica("t6_apaga_a_zero", s_aa, 0);
        tecla(4'hA);
        tecla(4'hF);
        verifica("t6_f_ignorado", s_est, 1);
        verifica("t6_n_apaga", n_aa + n_ab, 0);
`endif

        verifica("exclusivos", n_excl, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
